pick_two_animator: RTL and testbench

PICK_TWO_ANIMATOR -- requirements
Module: pick_two_animator

---
 rtl/pick_two_animator.sv | 159 +++++++++++++++
 tb/tb_pick_two_animator.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pick_two_animator.sv
// rtl/pick_two_animator.sv - ring grow/hold/shrink animator stepped by synchronized frame ticks
module pick_two_animator #(
    parameter int RMIN        = 110,
    parameter int RMAX        = 200,
    parameter int GROW_STEP   = 2,
    parameter int HOLD_FRAMES = 60,
    parameter int ANGLE_STEP  = 6,
    parameter int ANGLE_WRAP  = 360
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start,
    input  logic       abort,
    input  logic [9:0] anchorX,
    input  logic [9:0] anchorY,
    output logic [9:0] centerX,
    output logic [9:0] centerY,
    output logic [9:0] radius,
    output logic [9:0] PickX,
    output logic       active,
    output logic       done
);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [9:0] X_LO = 10'd211;
    localparam logic [9:0] X_HI = 10'd428;
    localparam logic [9:0] Y_LO = 10'd211;
    localparam logic [9:0] Y_HI = 10'd268;

    typedef enum logic [1:0] {IDLE, GROW, HOLD, SHRINK} state_t;

    state_t        state_q, state_d;
    logic [9:0]    radius_q, radius_d, pick_q, pick_d, cx_q, cx_d, cy_q, cy_d;
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    logic          active_q, active_d, done_q, done_d;
    logic          sync1_q, sync2_q, edge_q, fill1_q, fill2_q, armed_q;
    logic          tick;
    logic [10:0]   pick_sum, rad_up;
    logic [9:0]    pick_next, rad_grow, rad_shrink;

    function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lo,
                                         input logic [9:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        return v;
    endfunction

    // A level already high at reset release must fall before its rise can count.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            fill1_q <= 1'b0;
            fill2_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
            fill1_q <= 1'b1;
            fill2_q <= fill1_q;
            if (fill2_q && !sync2_q)
                armed_q <= 1'b1;
        end
    end

    assign tick = sync2_q & ~edge_q & armed_q;

    always_comb begin
        pick_sum   = {1'b0, pick_q} + 11'(ANGLE_STEP);
        pick_next  = (pick_sum >= 11'(ANGLE_WRAP)) ? 10'(pick_sum - 11'(ANGLE_WRAP))
                                                   : pick_sum[9:0];
        rad_up     = {1'b0, radius_q} + 11'(GROW_STEP);
        rad_grow   = (rad_up >= 11'(RMAX)) ? 10'(RMAX) : rad_up[9:0];
        rad_shrink = ({1'b0, radius_q} <= 11'(RMIN + GROW_STEP)) ? 10'(RMIN)
                                                                 : radius_q - 10'(GROW_STEP);
        hold_inc   = hold_q + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        radius_d = radius_q;
        pick_d   = pick_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        hold_d   = hold_q;
        done_d   = 1'b0;
        if (abort) begin
            state_d  = IDLE;
            radius_d = 10'(RMIN);
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d  = GROW;
                    radius_d = 10'(RMIN);
                    pick_d   = 10'd0;
                    cx_d     = clamp(anchorX, X_LO, X_HI);
                    cy_d     = clamp(anchorY, Y_LO, Y_HI);
                end
                GROW: if (tick) begin
                    pick_d   = pick_next;
                    radius_d = rad_grow;
                    if (rad_grow == 10'(RMAX)) begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end
                end
                HOLD: if (tick) begin
                    pick_d = pick_next;
                    hold_d = hold_inc;
                    if (hold_inc == HW'(HOLD_FRAMES))
                        state_d = SHRINK;
                end
                SHRINK: if (tick) begin
                    pick_d   = pick_next;
                    radius_d = rad_shrink;
                    if (rad_shrink == 10'(RMIN)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            radius_q <= 10'(RMIN);
            pick_q   <= 10'd0;
            cx_q     <= 10'd320;
            cy_q     <= 10'd240;
            hold_q   <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            radius_q <= radius_d;
            pick_q   <= pick_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            hold_q   <= hold_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign centerX = cx_q;
    assign centerY = cy_q;
    assign radius  = radius_q;
    assign PickX   = pick_q;
    assign active  = active_q;
    assign done    = done_q;
endmodule

// File: tb/tb_pick_two_animator.sv
// tb/tb_pick_two_animator.sv - directed plus randomized checks against a closed-form ring model
module tb_pick_two_animator;
    localparam int RMIN = 110, RMAX = 200, GS = 2, HF = 60, AS = 6, AW = 360;
    localparam int GT = (RMAX - RMIN) / GS;
    localparam int NT = 2 * GT + HF;

    logic       CLK = 1'b0, Reset = 1'b0, frame_clk = 1'b0, start = 1'b0, abort = 1'b0;
    logic [9:0] anchorX = '0, anchorY = '0;
    logic [9:0] centerX, centerY, radius, PickX;
    logic       active, done;
    int         total = 0, bad = 0, done_cnt = 0, dc0;
    int         ex_cx, ex_cy, n;

    pick_two_animator dut (
        .CLK(CLK), .Reset(Reset), .frame_clk(frame_clk), .start(start), .abort(abort),
        .anchorX(anchorX), .anchorY(anchorY), .centerX(centerX), .centerY(centerY),
        .radius(radius), .PickX(PickX), .active(active), .done(done)
    );

    always #5 CLK = ~CLK;
    always @(negedge CLK) if (done === 1'b1) done_cnt++;

    function automatic int m_radius(input int k);
        if (k <= GT) return RMIN + GS * k;
        if (k <= GT + HF) return RMAX;
        return RMAX - GS * (k - GT - HF);
    endfunction

    function automatic int m_pick(input int k);
        return (k * AS) % AW;
    endfunction

    function automatic int m_clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic frame_tick();
        @(negedge CLK) frame_clk = 1'b1;
        repeat (4) @(negedge CLK);
        frame_clk = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic pulse_start(input int x, input int y);
        @(negedge CLK);
        start = 1'b1; anchorX = 10'(x); anchorY = 10'(y);
        @(negedge CLK) start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge CLK) abort = 1'b1;
        @(negedge CLK) abort = 1'b0;
    endtask

    task automatic run_ticks(input int from, input int upto, input string tag);
        for (int k = from + 1; k <= upto; k++) begin
            frame_tick();
            chk({tag, "_radius"}, radius, m_radius(k));
            chk({tag, "_pick"}, PickX, m_pick(k));
            chk({tag, "_active"}, active, (k < NT) ? 1 : 0);
        end
    endtask

    initial begin
        #1 Reset = 1'b1;
        #3;
        chk("rst_radius", radius, RMIN);
        chk("rst_pick", PickX, 0);
        chk("rst_cx", centerX, 320);
        chk("rst_cy", centerY, 240);
        chk("rst_active", active, 0);
        chk("rst_done", done, 0);
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        repeat (6) @(negedge CLK);

        // full animation from centred anchor
        pulse_start(320, 240);
        chk("run_cx", centerX, 320);
        chk("run_cy", centerY, 240);
        chk("run_active0", active, 1);
        chk("run_radius0", radius, RMIN);
        dc0 = done_cnt;
        run_ticks(0, NT, "full");
        chk("full_done_once", done_cnt - dc0, 1);
        frame_tick();
        chk("idle_hold_radius", radius, RMIN);
        chk("idle_hold_pick", PickX, m_pick(NT));

        // clamp corner case then randomized anchors
        pulse_start(5, 470);
        chk("clamp_cx", centerX, 211);
        chk("clamp_cy", centerY, 268);
        for (int i = 0; i < 8; i++) begin
            dc0 = done_cnt;
            pulse_abort();
            chk("abort_active", active, 0);
            chk("abort_radius", radius, RMIN);
            chk("abort_nodone", done_cnt - dc0, 0);
            ex_cx = $urandom_range(0, 1023);
            ex_cy = $urandom_range(0, 1023);
            pulse_start(ex_cx, ex_cy);
            chk("rclamp_cx", centerX, m_clamp(ex_cx, 211, 428));
            chk("rclamp_cy", centerY, m_clamp(ex_cy, 211, 268));
        end
        pulse_abort();

        // ignored start mid-run, then abort+start colliding with a tick
        pulse_start(300, 250);
        run_ticks(0, 20, "ign");
        pulse_start(400, 220);
        chk("ign_cx", centerX, 300);
        chk("ign_cy", centerY, 250);
        chk("ign_radius", radius, 150);
        run_ticks(20, 100, "pre_abort");
        dc0 = done_cnt;
        @(negedge CLK);
        frame_clk = 1'b1; abort = 1'b1; start = 1'b1; anchorX = 10'd400; anchorY = 10'd220;
        repeat (4) @(negedge CLK);
        abort = 1'b0; start = 1'b0; frame_clk = 1'b0;
        chk("prio_active", active, 0);
        chk("prio_radius", radius, RMIN);
        chk("prio_done", done, 0);
        chk("prio_cx", centerX, 300);
        repeat (4) @(negedge CLK);
        chk("prio_nodone", done_cnt - dc0, 0);

        // randomized partial runs ended by abort
        for (int i = 0; i < 3; i++) begin
            n = $urandom_range(1, NT - 1);
            pulse_start(320, 240);
            run_ticks(0, n, "part");
            pulse_abort();
            chk("part_active", active, 0);
            chk("part_radius", radius, RMIN);
        end

        // asynchronous reset mid-HOLD
        pulse_start(350, 230);
        run_ticks(0, GT + 20, "hold");
        dc0 = done_cnt;
        @(negedge CLK) #1 Reset = 1'b1;
        #1;
        chk("arst_radius", radius, RMIN);
        chk("arst_pick", PickX, 0);
        chk("arst_cx", centerX, 320);
        chk("arst_cy", centerY, 240);
        chk("arst_active", active, 0);
        chk("arst_done", done, 0);
        frame_clk = 1'b1;
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        repeat (6) @(negedge CLK);
        chk("arst_nodone", done_cnt - dc0, 0);
        pulse_start(320, 240);
        repeat (10) @(negedge CLK);
        chk("high_no_tick_radius", radius, RMIN);
        chk("high_no_tick_pick", PickX, 0);
        frame_clk = 1'b0;
        repeat (4) @(negedge CLK);
        run_ticks(0, 3, "rearm");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
